// File: rtl/filter_addr_if.sv
// Read-request channel between the filter address scheduler and filter memory.
//   rd_valid   : scheduler has a valid request on rd_addr
//   rd_ready   : memory accepts the request this cycle
//   rd_addr    : element address
//   filter_idx : index of the filter being read
//   last_elem  : final element of the current filter (qualified by rd_valid)
interface filter_addr_if #(
  parameter int ADDR_WIDTH    = 16,
  parameter int NUM_FILTERS_W = 4
);
  logic                     rd_valid;
  logic                     rd_ready;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [NUM_FILTERS_W-1:0] filter_idx;
  logic                     last_elem;

  modport master (
    output rd_valid, rd_addr, filter_idx, last_elem,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_addr, filter_idx, last_elem,
    output rd_ready
  );
endinterface

// File: rtl/filter_addr_scheduler.sv
// Walks num_filters filters of filter_size elements each, issuing one read
// address per accepted transfer. Filters start filter_size (or 2*filter_size
// when interleaved) apart; all address arithmetic wraps at ADDR_WIDTH.
//   clk, rst (async, active-low)
//   start, abort            : schedule control
//   base_addr, filter_size,
//   num_filters,
//   interleaved_mode        : configuration, latched on accepted start
//   rd (master)             : read-request channel
//   busy, done              : status (busy in RUN, done one-cycle pulse)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing element addresses
// DONE  | one-cycle completion pulse
module filter_addr_scheduler #(
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_FILTER_SIZE = 4,
  parameter int NUM_FILTERS_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [MAX_FILTER_SIZE-1:0] filter_size,
  input  logic [NUM_FILTERS_W-1:0]   num_filters,
  input  logic                       interleaved_mode,
  filter_addr_if.master              rd,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state, state_next;
  logic [MAX_FILTER_SIZE-1:0] size_q;
  logic [NUM_FILTERS_W-1:0]   num_q;
  logic                       interleaved_q;
  logic [ADDR_WIDTH-1:0]      filter_start;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [MAX_FILTER_SIZE-1:0] elem_cnt;
  logic [NUM_FILTERS_W-1:0]   idx_q;
  logic [ADDR_WIDTH-1:0]      size_ext;
  logic [ADDR_WIDTH-1:0]      stride;
  logic [ADDR_WIDTH-1:0]      next_start;
  logic                       valid;
  logic                       last;
  logic                       last_filter;
  logic                       xfer;

  assign valid       = (state == RUN);
  assign last        = valid && (elem_cnt == size_q - MAX_FILTER_SIZE'(1));
  assign last_filter = (idx_q == num_q - NUM_FILTERS_W'(1));
  assign xfer        = valid && rd.rd_ready;

  assign size_ext   = ADDR_WIDTH'(size_q);
  assign stride     = interleaved_q ? (size_ext << 1) : size_ext;
  assign next_start = filter_start + stride;

  assign rd.rd_valid   = valid;
  assign rd.rd_addr    = addr_q;
  assign rd.filter_idx = idx_q;
  assign rd.last_elem  = last;
  assign busy          = valid;
  assign done          = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (filter_size != '0 && num_filters != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (xfer && last && last_filter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A transfer coincident with abort still advances the pointers; the
  // request simply is not re-issued because the FSM leaves RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      size_q        <= '0;
      num_q         <= '0;
      interleaved_q <= 1'b0;
      filter_start  <= '0;
      addr_q        <= '0;
      elem_cnt      <= '0;
      idx_q         <= '0;
    end else if (state == IDLE && start) begin
      size_q        <= filter_size;
      num_q         <= num_filters;
      interleaved_q <= interleaved_mode;
      filter_start  <= base_addr;
      addr_q        <= base_addr;
      elem_cnt      <= '0;
      idx_q         <= '0;
    end else if (xfer) begin
      if (last) begin
        filter_start <= next_start;
        addr_q       <= next_start;
        elem_cnt     <= '0;
        idx_q        <= idx_q + NUM_FILTERS_W'(1);
      end else begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        elem_cnt <= elem_cnt + MAX_FILTER_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_filter_addr_scheduler.sv
// Directed bench for filter_addr_scheduler. Inputs are driven and outputs
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_filter_addr_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [3:0]  filter_size;
  logic [3:0]  num_filters;
  logic        interleaved_mode;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  logic [15:0] ea [8];
  logic [3:0]  ei [8];
  logic        el [8];

  filter_addr_if #(.ADDR_WIDTH(16), .NUM_FILTERS_W(4)) rd_if ();

  filter_addr_scheduler #(
    .ADDR_WIDTH(16), .MAX_FILTER_SIZE(4), .NUM_FILTERS_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .filter_size(filter_size),
    .num_filters(num_filters), .interleaved_mode(interleaved_mode),
    .rd(rd_if.master), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present config with start for one rising edge; returns at the falling
  // edge right after the accepting edge.
  task automatic start_sched(input logic [15:0] b, input logic [3:0] s,
                             input logic [3:0] n, input logic il);
    base_addr = b; filter_size = s; num_filters = n; interleaved_mode = il;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_valid%0d", name, i), 32'(rd_if.rd_valid), 32'd1);
      chk($sformatf("%s_addr%0d", name, i), 32'(rd_if.rd_addr), 32'(ea[i]));
      chk($sformatf("%s_idx%0d", name, i), 32'(rd_if.filter_idx), 32'(ei[i]));
      chk($sformatf("%s_last%0d", name, i), 32'(rd_if.last_elem), 32'(el[i]));
      @(negedge clk);
    end
  endtask

  task automatic chk_done_pulse(input string name);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_valid_off"}, 32'(rd_if.rd_valid), 32'd0);
    chk({name, "_busy_off"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({name, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; filter_size = '0; num_filters = '0; interleaved_mode = 1'b0;
    rd_if.rd_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("rst_addr", 32'(rd_if.rd_addr), 32'd0);
    chk("rst_idx", 32'(rd_if.filter_idx), 32'd0);
    chk("rst_last", 32'(rd_if.last_elem), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);

    // Two contiguous filters of three
    ea = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h104, 16'h105, 0, 0};
    ei = '{0, 0, 0, 1, 1, 1, 0, 0};
    el = '{0, 0, 1, 0, 0, 1, 0, 0};
    start_sched(16'h0100, 4'd3, 4'd2, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    run_stream("t1", 6);
    chk_done_pulse("t1");

    // Interleaved stride; start and config churn during RUN are ignored
    ea = '{16'h0, 16'h1, 16'h4, 16'h5, 16'h8, 16'h9, 0, 0};
    ei = '{0, 0, 1, 1, 2, 2, 0, 0};
    el = '{0, 1, 0, 1, 0, 1, 0, 0};
    start_sched(16'h0000, 4'd2, 4'd3, 1'b1);
    start = 1'b1; base_addr = 16'h7777; filter_size = 4'd9; interleaved_mode = 1'b0;
    run_stream("t2", 6);
    start = 1'b0;
    chk_done_pulse("t2");

    // Back-pressure: request held for three stalled cycles
    rd_if.rd_ready = 1'b0;
    start_sched(16'h0020, 4'd2, 4'd1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t3_hold_addr%0d", c), 32'(rd_if.rd_addr), 32'h20);
      chk($sformatf("t3_hold_valid%0d", c), 32'(rd_if.rd_valid), 32'd1);
      chk($sformatf("t3_hold_last%0d", c), 32'(rd_if.last_elem), 32'd0);
      @(negedge clk);
    end
    rd_if.rd_ready = 1'b1;
    ea = '{16'h20, 16'h21, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    el = '{0, 1, 0, 0, 0, 0, 0, 0};
    run_stream("t3", 2);
    chk_done_pulse("t3");

    // Address wrap
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 0, 0, 0, 0};
    ei = '{0, 0, 1, 1, 0, 0, 0, 0};
    el = '{0, 1, 0, 1, 0, 0, 0, 0};
    start_sched(16'hFFFE, 4'd2, 4'd2, 1'b0);
    run_stream("t4", 4);
    chk_done_pulse("t4");

    // Empty schedules go straight to DONE
    start_sched(16'h0050, 4'd0, 4'd2, 1'b0);
    chk_done_pulse("t5_size0");
    start_sched(16'h0050, 4'd3, 4'd0, 1'b0);
    chk_done_pulse("t5_num0");

    // Abort after two transfers; third transfer coincides with abort
    ea = '{16'h40, 16'h41, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    el = '{0, 0, 0, 0, 0, 0, 0, 0};
    start_sched(16'h0040, 4'd4, 4'd2, 1'b0);
    run_stream("t6", 2);
    chk("t6_abort_addr", 32'(rd_if.rd_addr), 32'h42);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_valid_off", 32'(rd_if.rd_valid), 32'd0);
    chk("t6_busy_off", 32'(busy), 32'd0);
    chk("t6_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("t6_no_done2", 32'(done), 32'd0);
    chk("t6_stay_idle", 32'(rd_if.rd_valid), 32'd0);

    // Asynchronous reset mid-RUN, then a fresh schedule
    ea = '{16'h300, 16'h301, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    el = '{0, 0, 0, 0, 0, 0, 0, 0};
    start_sched(16'h0300, 4'd4, 4'd2, 1'b0);
    run_stream("t7", 2);
    #2 rst = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("t7_rst_addr", 32'(rd_if.rd_addr), 32'd0);
    chk("t7_rst_idx", 32'(rd_if.filter_idx), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_last", 32'(rd_if.last_elem), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("t7_wait_start", 32'(rd_if.rd_valid), 32'd0);
    ea = '{16'h500, 0, 0, 0, 0, 0, 0, 0};
    el = '{1, 0, 0, 0, 0, 0, 0, 0};
    start_sched(16'h0500, 4'd1, 4'd1, 1'b0);
    run_stream("t7b", 1);
    chk_done_pulse("t7b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
